// File: rtl/audio_pkg.sv
// Shared types and constants for the PWM audio player: FSM states, silence level
// and the volume scaling helper used in front of the PWM generator.
package audio_pkg;

    localparam int PWM_BITS = 8;
    localparam logic [PWM_BITS-1:0] SILENCE = 8'd128;
    localparam int DEFAULT_CLK_FREQ = 50_000_000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_HOLD
    } state_t;

    // Attenuate around the mid-scale point so silence stays at 128 for every volume.
    function automatic logic [PWM_BITS-1:0] scale_sample(input logic [PWM_BITS-1:0] sample,
                                                         input logic [1:0] shift);
        logic signed [PWM_BITS:0] offset;
        logic signed [PWM_BITS:0] scaled;
        offset = $signed({1'b0, sample}) - 9'sd128;
        scaled = offset >>> shift;
        return scaled[PWM_BITS-1:0] + SILENCE;
    endfunction

endpackage

// File: rtl/pwm_audio_player_if.sv
// Pop-style read interface between the player and its upstream byte buffer.
interface pwm_audio_player_if;

    logic       buf_empty;
    logic [7:0] buf_data;
    logic       buf_valid;
    logic       read_en;

    modport master (output read_en, input buf_empty, input buf_data, input buf_valid);
    modport slave  (input read_en, output buf_empty, output buf_data, output buf_valid);

endinterface

// File: rtl/pwm_audio_player_pwm_gen.sv
// Free-running PWM generator; the duty register only updates on counter wrap so a
// period is never cut short or stretched by a mid-period duty change.
module pwm_gen
    import audio_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PWM_BITS-1:0] duty_in,
    output logic [PWM_BITS-1:0] duty,
    output logic                pwm_out
);

    logic [PWM_BITS-1:0] count;

    // pwm_out is registered so reset drives the pin low even though duty resets to mid-scale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            duty    <= SILENCE;
            pwm_out <= 1'b0;
        end else begin
            count   <= count + 1'b1;
            if (count == '1)
                duty <= duty_in;
            pwm_out <= (count < duty);
        end
    end

endmodule

// File: rtl/pwm_audio_player.sv
// PWM audio player: fetches one byte per sample tick from an upstream buffer,
// applies volume attenuation and plays it through a wrap-synchronised PWM.
module pwm_audio_player
    import audio_pkg::*;
#(
    parameter int CLK_FREQ    = DEFAULT_CLK_FREQ,
    parameter int SAMPLE_RATE = 8_000,
    parameter int WAIT_LIMIT  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic [1:0]                 volume,
    pwm_audio_player_if.master         bus,
    output logic                       pwm_out,
    output logic [PWM_BITS-1:0]        duty,
    output logic [15:0]                underrun_count,
    output logic                       playing
);

    localparam int SAMPLE_DIV = CLK_FREQ / SAMPLE_RATE;
    localparam int TICK_W     = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int WAIT_W     = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_DIV - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_LIMIT - 1);

    logic [TICK_W-1:0]   tick_count;
    logic                tick;
    state_t              state, state_d;
    logic [PWM_BITS-1:0] target, target_d;
    logic [WAIT_W-1:0]   wait_count, wait_d;
    logic                underrun;
    logic [PWM_BITS-1:0] duty_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tick_count <= '0;
        else if (!enable || tick_count == TICK_LAST)
            tick_count <= '0;
        else
            tick_count <= tick_count + 1'b1;
    end

    assign tick = enable && (tick_count == TICK_LAST);

    // A tick only matters in IDLE/HOLD; FETCH/WAIT never see an underrun from a tick,
    // which keeps capture and underrun mutually exclusive.
    always_comb begin
        state_d     = state;
        target_d    = target;
        wait_d      = wait_count;
        underrun    = 1'b0;
        bus.read_en = 1'b0;
        if (!enable) begin
            state_d  = ST_IDLE;
            target_d = SILENCE;
            wait_d   = '0;
        end else begin
            case (state)
                ST_IDLE, ST_HOLD: begin
                    if (tick) begin
                        if (!bus.buf_empty) begin
                            state_d = ST_FETCH;
                        end else begin
                            state_d  = ST_IDLE;
                            target_d = SILENCE;
                            underrun = 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    if (bus.buf_empty) begin
                        state_d  = ST_IDLE;
                        target_d = SILENCE;
                        underrun = 1'b1;
                    end else begin
                        bus.read_en = 1'b1;
                        state_d     = ST_WAIT;
                        wait_d      = '0;
                    end
                end
                ST_WAIT: begin
                    if (bus.buf_valid) begin
                        target_d = bus.buf_data;
                        state_d  = ST_HOLD;
                    end else if (wait_count == WAIT_LAST) begin
                        target_d = SILENCE;
                        underrun = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        wait_d = wait_count + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            target         <= SILENCE;
            wait_count     <= '0;
            underrun_count <= '0;
        end else begin
            state      <= state_d;
            target     <= target_d;
            wait_count <= wait_d;
            if (underrun && underrun_count != 16'hFFFF)
                underrun_count <= underrun_count + 16'd1;
        end
    end

    assign playing = (state == ST_HOLD);
    assign duty_in = scale_sample(target, volume);

    pwm_gen u_pwm_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .duty_in (duty_in),
        .duty    (duty),
        .pwm_out (pwm_out)
    );

endmodule

// File: tb/tb_pwm_audio_player.sv
// Directed self-checking bench for pwm_audio_player with a shortened sample period
// (600 clocks) and a small buffer model that answers read_en one cycle later.
module tb_pwm_audio_player;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [1:0]  volume;
    logic        pwm_out;
    logic [7:0]  duty;
    logic [15:0] underrun_count;
    logic        playing;

    int compared   = 0;
    int mismatched = 0;
    int rd_count   = 0;
    int rd_base    = 0;
    int highs      = 0;
    logic [15:0] u_base;
    bit respond     = 1'b0;
    bit force_valid = 1'b0;
    bit rd_seen     = 1'b0;

    pwm_audio_player_if bus ();

    pwm_audio_player #(
        .CLK_FREQ    (6000),
        .SAMPLE_RATE (10),
        .WAIT_LIMIT  (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .volume         (volume),
        .bus            (bus.master),
        .pwm_out        (pwm_out),
        .duty           (duty),
        .underrun_count (underrun_count),
        .playing        (playing)
    );

    always #5 clk = ~clk;

    // Count pop requests at the clock edge where the DUT acts on them.
    initial begin
        forever begin
            @(posedge clk);
            rd_seen = bus.read_en;
            if (rst_n && bus.read_en)
                rd_count++;
        end
    end

    // Buffer model: valid one cycle after read_en, or forced by the directed sequence.
    initial begin
        bus.buf_valid = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            bus.buf_valid = (respond && rd_seen) || force_valid;
        end
    end

    task automatic check_output(input string tag, input logic [15:0] observed,
                                input logic [15:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_playing(input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (playing === 1'b1) break;
        end
    endtask

    task automatic wait_read(input int base, input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (rd_count > base) break;
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        enable        = 1'b0;
        volume        = 2'd0;
        bus.buf_empty = 1'b1;
        bus.buf_data  = 8'h00;

        wait_cycles(3);
        check_output("rst_pwm_out", 16'(pwm_out), 16'd0);
        check_output("rst_read_en", 16'(bus.read_en), 16'd0);
        check_output("rst_duty", 16'(duty), 16'd128);
        check_output("rst_underrun", underrun_count, 16'd0);
        check_output("rst_playing", 16'(playing), 16'd0);

        rst_n         = 1'b1;
        enable        = 1'b1;
        bus.buf_empty = 1'b0;
        bus.buf_data  = 8'hFF;
        respond       = 1'b1;
        wait_cycles(500);
        check_output("no_read_before_tick", 16'(rd_count), 16'd0);
        wait_playing(200);
        check_output("first_tick_playing", 16'(playing), 16'd1);
        check_output("first_tick_one_read", 16'(rd_count), 16'd1);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (duty === 8'd255) break;
        end
        check_output("full_scale_duty", 16'(duty), 16'd255);
        highs = 0;
        repeat (256) begin
            @(negedge clk);
            if (pwm_out === 1'b1) highs++;
        end
        check_output("full_scale_high_cycles", 16'(highs), 16'd255);

        bus.buf_empty = 1'b1;
        rd_base       = rd_count;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (underrun_count === 16'd3) break;
        end
        check_output("empty_underrun_3", underrun_count, 16'd3);
        wait_cycles(300);
        check_output("empty_underrun_stable", underrun_count, 16'd3);
        check_output("empty_no_read", 16'(rd_count - rd_base), 16'd0);
        check_output("empty_duty_silence", 16'(duty), 16'd128);
        check_output("empty_not_playing", 16'(playing), 16'd0);

        volume        = 2'd2;
        bus.buf_data  = 8'h00;
        bus.buf_empty = 1'b0;
        wait_playing(700);
        check_output("vol2_playing", 16'(playing), 16'd1);
        wait_cycles(300);
        check_output("vol2_sample00_duty", 16'(duty), 16'd96);
        volume       = 2'd3;
        bus.buf_data = 8'hFF;
        wait_cycles(700);
        check_output("vol3_sampleFF_duty", 16'(duty), 16'd143);

        respond = 1'b0;
        u_base  = underrun_count;
        rd_base = rd_count;
        wait_read(rd_base, 700);
        check_output("timeout_read_issued", 16'(rd_count - rd_base), 16'd1);
        wait_cycles(6);
        check_output("timeout_underrun_inc", underrun_count, u_base + 16'd1);
        check_output("timeout_not_playing", 16'(playing), 16'd0);
        wait_cycles(300);
        check_output("timeout_duty_silence", 16'(duty), 16'd128);

        u_base  = underrun_count;
        rd_base = rd_count;
        wait_read(rd_base, 700);
        check_output("disable_read_issued", 16'(rd_count - rd_base), 16'd1);
        enable       = 1'b0;
        force_valid  = 1'b1;
        bus.buf_data = 8'hFF;
        @(negedge clk);
        force_valid = 1'b0;
        wait_cycles(700);
        check_output("disable_not_playing", 16'(playing), 16'd0);
        check_output("disable_no_more_read", 16'(rd_count - rd_base), 16'd1);
        check_output("disable_byte_discarded", 16'(duty), 16'd128);
        check_output("disable_no_underrun", underrun_count, u_base);

        enable  = 1'b1;
        respond = 1'b1;
        wait_playing(700);
        check_output("hold_before_reset", 16'(playing), 16'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("async_rst_pwm_out", 16'(pwm_out), 16'd0);
        check_output("async_rst_read_en", 16'(bus.read_en), 16'd0);
        check_output("async_rst_duty", 16'(duty), 16'd128);
        check_output("async_rst_underrun", underrun_count, 16'd0);
        check_output("async_rst_playing", 16'(playing), 16'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        rd_base = rd_count;
        wait_cycles(300);
        check_output("post_rst_no_read", 16'(rd_count - rd_base), 16'd0);
        check_output("post_rst_duty", 16'(duty), 16'd128);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pwm_audio_player.md
PWM_AUDIO_PLAYER -- requirements
Module: pwm_audio_player

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter SAMPLE_RATE, default 8_000, audio sample rate in Hz; SAMPLE_DIV = CLK_FREQ/SAMPLE_RATE (6250 at defaults).
REQ-003 Parameter WAIT_LIMIT, default 4, maximum cycles to wait for buffer data_valid after a read.
REQ-004 Port clk  input  1  single system clock; all logic on rising edge.
REQ-005 Port rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port enable  input  1  playback enable; 0 forces silence and stops fetching.
REQ-007 Port volume  input  2  attenuation shift 0..3; 0 = full scale.
REQ-008 Port buf_empty  input  1  upstream byte buffer empty flag.
REQ-009 Port buf_data  input  8  upstream buffer read data, unsigned sample with 128 = silence.
REQ-010 Port buf_valid  input  1  upstream read data valid strobe.
REQ-011 Port read_en  output  1  single-cycle pop request to the upstream buffer.
REQ-012 Port pwm_out  output  1  PWM audio output, drives the GPIO audio pin.
REQ-013 Port duty  output  8  duty value currently applied to the PWM.
REQ-014 Port underrun_count  output  16  saturating count of sample ticks with no data.
REQ-015 Port playing  output  1  high while the FSM is in HOLD with a valid sample.

Function
REQ-016 Sample tick: counter 0..SAMPLE_DIV-1 runs only while enable=1; tick pulses one cycle when the counter equals SAMPLE_DIV-1; the counter then returns to 0; it is cleared when enable=0.
REQ-017 FSM states: IDLE, FETCH, WAIT, HOLD.
REQ-018 IDLE -> FETCH on tick with buf_empty=0; on tick with buf_empty=1 stay in IDLE, set target sample to 128, increment underrun_count.
REQ-019 FETCH: read_en=1 for exactly one cycle, then -> WAIT; read_en is never asserted in any other state or while buf_empty=1.
REQ-020 WAIT: capture buf_data into the target sample on the first cycle buf_valid=1, -> HOLD; if WAIT_LIMIT cycles elapse without buf_valid, set target 128, increment underrun_count, -> IDLE.
REQ-021 HOLD: on the next tick behave exactly as IDLE on a tick (fetch or underrun); playing=1 only in HOLD.
REQ-022 enable=0 in any state: -> IDLE at the next cycle, target forced to 128, no read_en issued; a byte arriving in WAIT is discarded.
REQ-023 Volume: offset = target - 128 (signed 9-bit); scaled = offset arithmetically shifted right by volume; scaled duty = scaled + 128, truncated to 8 bits (range always 0..255, no overflow).
REQ-024 PWM: free-running 8-bit counter; pwm_out = (counter < duty); duty 0 gives constant 0 and duty 255 gives 255 high cycles per 256.
REQ-025 The duty register loads the scaled duty only when the PWM counter wraps 255 -> 0 (glitch-free update); a duty change takes effect within 256 cycles.
REQ-026 underrun_count saturates at 16'hFFFF and never wraps.
REQ-027 Underrun and capture are mutually exclusive per tick; a tick coinciding with buf_valid in WAIT does not count as an underrun.

Reset
REQ-028 On rst_n=0, immediately: FSM = IDLE, read_en = 0, pwm_out = 0, duty = 128, target = 128, PWM and tick counters = 0, underrun_count = 0, playing = 0.
REQ-029 Reset asserted mid-FETCH or mid-WAIT abandons the transfer; no state is retained after release.

Structure
REQ-030 Package audio_pkg holds the FSM state enum, SILENCE = 8'd128, PWM_BITS = 8 and the shared CLK_FREQ default.
REQ-031 One sub-module, pwm_gen, contains the PWM counter, the wrap-synchronised duty register and the comparator.

Verification
REQ-032 Hold rst_n=0 -> pwm_out=0, read_en=0, duty=128, underrun_count=0; release -> no read_en until the first tick.
REQ-033 Preload 0xFF, volume=0, enable=1 -> exactly one read_en at the first tick; after the next PWM wrap, duty=255 and pwm_out is high for 255 of 256 cycles.
REQ-034 buf_empty=1 for 3 ticks -> zero read_en pulses, underrun_count=3, duty=128.
REQ-035 Sample 0x00 with volume=2 -> duty=96; sample 0xFF with volume=3 -> duty=143.
REQ-036 buf_valid withheld for 4 cycles after read_en -> underrun_count increments by 1, FSM returns to IDLE, duty=128.
REQ-037 Drop enable mid-WAIT, then pulse rst_n low mid-HOLD -> the byte is discarded with no further read_en, and all outputs return to their reset values asynchronously.
